// File: rtl/store_buf_pkg.sv
// store_buf_pkg: store size encodings and buffered entry record shared by the store buffer.
package store_buf_pkg;
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: moves right-justified store data onto its byte lanes and flags misaligned or unknown sizes.
module store_lane_align
  import store_buf_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        illegal
);
  assign illegal = (size == SZ_BYTE) ? 1'b0 :
                   (size == SZ_HALF) ? off[0] :
                   (size == SZ_WORD) ? (off != 2'b00) : 1'b1;
  assign be = (size == SZ_BYTE) ? 4'b0001 << off :
              (size == SZ_HALF) ? 4'b0011 << off : 4'b1111;
  assign wdata = (size == SZ_BYTE) ? {24'b0, data[7:0]} << {off, 3'b000} :
                 (size == SZ_HALF) ? {16'b0, data[15:0]} << {off[1], 4'b0000} : data;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of aligned stores toward data memory with load-hazard detection.
// Define STORE_BUF_LD_MATCH_EN for word-address load matching; otherwise any pending store stalls loads.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_size,
  output logic                       st_err,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  sb_entry_t      buf_q [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [3:0]     al_be;
  logic [31:0]    al_wdata;
  logic           illegal, hs, push, pop;
  sb_entry_t      head;
  store_lane_align u_align (
    .off(st_addr[1:0]), .size(st_size), .data(st_data),
    .be(al_be), .wdata(al_wdata), .illegal(illegal)
  );
  assign st_ready  = count != (AW+1)'(DEPTH);
  assign hs        = st_valid && st_ready;
  assign push      = hs && !illegal;
  assign mem_req   = count != '0;
  assign pop       = mem_req && mem_ack;
  assign head      = buf_q[rd_ptr];
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_wdata = head.wdata;
  assign mem_be    = head.be;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      st_err <= hs && illegal;
    end
  end
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= '{waddr: st_addr[31:2], wdata: al_wdata, be: al_be};
  end
`ifdef STORE_BUF_LD_MATCH_EN
  logic unused_ld_off;
  assign unused_ld_off = ^ld_addr[1:0];
  // walk from the head so only occupied slots are compared
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ((AW+1)'(i) < count && buf_q[rd_ptr + AW'(i)].waddr == ld_addr[31:2]) ld_hit = ld_valid;
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit = ld_valid && (count != '0);
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1;
  logic st_valid = 0, st_ready, st_err, mem_req, mem_ack = 0, ld_valid = 0, ld_hit;
  logic [31:0] st_addr = 0, st_data = 0, mem_addr, mem_wdata, ld_addr = 0;
  logic [2:0] st_size = 0;
  logic [3:0] mem_be;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} ent_t;
  ent_t q[$];
  bit err_exp = 0;
  always #5 clk = ~clk;
  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_err(st_err), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .count(count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                     input logic ack, input logic lv, input logic [31:0] la);
    ent_t e;
    bit legal, push, pop, hit;
    int off;
    @(negedge clk);
    st_valid = v; st_addr = a; st_data = d; st_size = s; mem_ack = ack; ld_valid = lv; ld_addr = la;
    #1;
    hit = 0;
    foreach (q[k]) if (q[k].addr[31:2] == la[31:2]) hit = 1;
`ifndef STORE_BUF_LD_MATCH_EN
    hit = q.size() != 0;
`endif
    chk("count", count, q.size());
    chk("st_ready", st_ready, q.size() != DEPTH);
    chk("mem_req", mem_req, q.size() != 0);
    chk("st_err", st_err, err_exp);
    chk("ld_hit", ld_hit, lv && hit);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, {q[0].addr[31:2], 2'b00});
      chk("mem_wdata", mem_wdata, q[0].data);
      chk("mem_be", mem_be, q[0].be);
    end
    off = a[1:0];
    legal = (s == 0) || (s == 1 && off % 2 == 0) || (s == 2 && off == 0);
    e.addr = a;
    e.be = (s == 0) ? 4'(1 << off) : (s == 1) ? 4'(3 << off) : 4'hf;
    e.data = (s == 0) ? (d & 32'hff) << (8 * off) : (s == 1) ? (d & 32'hffff) << (8 * off) : d;
    push = v && q.size() != DEPTH;
    pop = ack && q.size() != 0;
    err_exp = push && !legal;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push && legal) q.push_back(e);
  endtask
  task automatic idle(input logic ack);
    cyc(0, 0, 0, 0, ack, 0, 0);
  endtask
  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_st_err", st_err, 0);
    @(negedge clk); rst = 0;
    #1 chk("rst_st_ready", st_ready, 1);
    // byte store into the top lane
    cyc(1, 32'h1003, 32'hAB, 3'b000, 0, 0, 0);
    #1;
    chk("sb_addr", mem_addr, 32'h1000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB000000);
    idle(1);
    // misaligned half
    cyc(1, 32'h2001, 32'h1234, 3'b001, 0, 0, 0);
    #1;
    chk("sh_err", st_err, 1);
    chk("sh_count", count, 0);
    chk("sh_mem_req", mem_req, 0);
    idle(0);
    #1 chk("sh_err_clear", st_err, 0);
    // fill, then one ack
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 4 * i, 32'hA0 + i, 3'b010, 0, 0, 0);
    #1;
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    cyc(1, 32'h200, 32'hDEAD, 3'b010, 1, 0, 0);
    #1;
    chk("ack_count", count, 3);
    chk("ack_ready", st_ready, 1);
    chk("ack_order", mem_wdata, 32'hA1);
    for (int i = 0; i < 3; i++) idle(1);
    // full buffer streaming with ack held
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 4 * i, 32'hB0 + i, 3'b010, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 32'h400 + 4 * i, 32'hC0 + i, 3'b010, 1, 0, 0);
    while (q.size() != 0) idle(1);
    // load hazard
    cyc(1, 32'h3004, 32'h55, 3'b010, 0, 1, 32'h3006);
    cyc(0, 0, 0, 0, 0, 1, 32'h3006);
    #1 chk("ld_3006", ld_hit, 1);
    cyc(0, 0, 0, 0, 0, 1, 32'h3008);
`ifdef STORE_BUF_LD_MATCH_EN
    chk("ld_3008", ld_hit, 0);
`else
    chk("ld_3008", ld_hit, 1);
`endif
    idle(1);
    // reset with stores pending
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 4 * i, 32'hD0 + i, 3'b010, 0, 0, 0);
    @(negedge clk);
    st_valid = 0; mem_ack = 0; rst = 1;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_count", count, 0);
    @(negedge clk); rst = 0;
    q.delete(); err_exp = 0;
    cyc(1, 32'h600, 32'hEE, 3'b010, 0, 0, 0);
    #1 chk("post_rst_head", mem_wdata, 32'hEE);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 32'h4000 + $urandom_range(0, 31), $urandom,
          3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          32'h4000 + $urandom_range(0, 31));
    while (q.size() != 0) idle(1);
    idle(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered stores; power of two, minimum 2.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: st_valid  input  1  store request from execute stage.
REQ-005 SHALL have port: st_ready  output  1  buffer accepts store this cycle.
REQ-006 SHALL have port: st_addr  input  32  byte address of store.
REQ-007 SHALL have port: st_data  input  32  store data, already size-selected and right-justified by the upstream store mux.
REQ-008 SHALL have port: st_size  input  3  000 byte, 001 half, 010 word (same encoding as the upstream store select).
REQ-009 SHALL have port: st_err  output  1  one-cycle pulse: last accepted request was rejected as misaligned or invalid size.
REQ-010 SHALL have port: mem_req  output  1  head entry valid toward data memory.
REQ-011 SHALL have port: mem_addr  output  32  word-aligned address; bits [1:0] = 00.
REQ-012 SHALL have port: mem_wdata  output  32  lane-aligned write data.
REQ-013 SHALL have port: mem_be  output  4  byte enables.
REQ-014 SHALL have port: mem_ack  input  1  memory consumed head entry this cycle.
REQ-015 SHALL have port: ld_valid  input  1  load in memory stage.
REQ-016 SHALL have port: ld_addr  input  32  load byte address.
REQ-017 SHALL have port: ld_hit  output  1  load must stall; combinational.
REQ-018 SHALL have port: count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-019 SHALL implement a FIFO of DEPTH entries {word addr, wdata, be}; st_ready = (count != DEPTH), independent of mem_ack.
REQ-020 SHALL perform a handshake when st_valid && st_ready; a legal store is written at the tail on that edge.
REQ-021 SHALL align data at enqueue: byte: be = 0001 << addr[1:0], data = st_data[7:0] << 8*addr[1:0]; half: be = 0011 << addr[1:0], data = st_data[15:0] << 16*addr[1]; word: be = 1111, data unshifted; unselected lanes = 0.
REQ-022 SHALL treat a handshake as illegal when: half with addr[0]=1; word with addr[1:0]!=00; or st_size in 011..111. An illegal handshake is not enqueued, and st_err = 1 for exactly the following cycle.
REQ-023 SHALL drive mem_req = (count != 0), with mem_addr/mem_wdata/mem_be from the head entry; outputs are stable while mem_req && !mem_ack.
REQ-024 SHALL pop the head on mem_req && mem_ack; mem_ack while mem_req=0 is ignored.
REQ-025 SHALL have an enqueue-to-mem_req latency of 1 cycle when empty; there is no combinational bypass.
REQ-026 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers; pointers wrap modulo DEPTH.
REQ-027 SHALL, when full with mem_ack, hold st_ready = 0 in that cycle; st_ready rises the next cycle.
REQ-028 SHALL compute ld_hit per the Configuration section, from occupied entries only; a same-cycle enqueue is not considered, and a same-cycle popping head is still considered.

Reset
REQ-029 SHALL, on rst assertion, asynchronously clear pointers and count, drive mem_req=0 and st_err=0 and st_ready=1 once released; entry contents are don't-care.
REQ-030 SHALL discard pending stores if rst asserts mid-operation; the first store after release is the only one presented.

Configuration
REQ-031 SHALL use the macro STORE_BUF_LD_MATCH_EN; when defined, ld_hit = ld_valid && any occupied entry with addr[31:2] == ld_addr[31:2].
REQ-032 SHALL, without the macro, compute ld_hit = ld_valid && (count != 0) (conservative stall); no address comparators are synthesized.

Structure
REQ-033 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the entry record typedef in shared package store_buf_pkg.
REQ-034 SHALL contain one combinational sub-module, store_lane_align (addr[1:0], size, data -> be, wdata, illegal).

Verification
REQ-035 SHALL cover: sb addr 0x1003 data 0x000000AB -> next cycle mem_addr 0x1000, be 1000, wdata 0xAB000000.
REQ-036 SHALL cover: sh addr 0x2001 -> st_err pulse one cycle, count stays 0, mem_req 0.
REQ-037 SHALL cover: 4 word stores with mem_ack=0 -> count 4, st_ready 0; one mem_ack -> count 3, st_ready 1 next cycle, order preserved.
REQ-038 SHALL cover: full buffer, mem_ack held 1 with st_valid held 1 -> steady throughput of one store per cycle after refill, no loss, no duplicates.
REQ-039 SHALL cover: pending sw 0x3004, load 0x3006 -> ld_hit 1; load 0x3008 -> ld_hit 1 without macro, 0 with macro.
REQ-040 SHALL cover: rst asserted with 3 entries pending -> mem_req 0 immediately, count 0 after release.
